// File: rtl/fs4_ddc_decim_if.sv
// -----------------------------------------------------------------------------
// fs4_ddc_decim_if
// Sample-stream bundle between the ADC front end, the fs/4 down-converter and
// the AGC.
//   master : upstream side.
//            Drives in_valid, in_data and sync.
//            Observes out_valid, out_real, out_imag and blk_phase.
//   slave  : the down-converter itself (the reverse directions).
// Signals:
//   in_valid  - qualifies in_data
//   in_data   - signed 16-bit ADC sample
//   sync      - synchronous restart of LO phase and decimation block
//   out_valid - one-cycle strobe per completed block (AGC en)
//   out_real  - signed 17-bit I result
//   out_imag  - signed 17-bit Q result
//   blk_phase - LO phase the next accepted sample will use
// -----------------------------------------------------------------------------
interface fs4_ddc_decim_if;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               sync;
  logic               out_valid;
  logic signed [16:0] out_real;
  logic signed [16:0] out_imag;
  logic        [1:0]  blk_phase;

  modport master (
    output in_valid, in_data, sync,
    input  out_valid, out_real, out_imag, blk_phase
  );

  modport slave (
    input  in_valid, in_data, sync,
    output out_valid, out_real, out_imag, blk_phase
  );
endinterface

// File: rtl/fs4_ddc_decim.sv
// -----------------------------------------------------------------------------
// fs4_ddc_decim
// Real-to-complex down-conversion by an fs/4 LO followed by integrate-and-dump
// decimation by 2^DEC_LOG2. This is the front end of the RACE chain, and it
// feeds the AGC.
// Ports:
//   clk  - system clock, rising edge
//   nrst - asynchronous active-low reset
//   bus  - fs4_ddc_decim_if.slave. It carries the input sample stream, sync,
//          the decimated I/Q with its strobe, and the current LO phase.
// Parameter:
//   DEC_LOG2 - log2 of the decimation factor. The legal range is 2..8, so
//              every block spans whole LO periods.
// Build option:
//   FS4_DDC_SPECTRAL_INV_EN - when defined, the Q mixer sign is flipped
//   (mix by +fs/4, spectrum inverted). Ports are identical in both builds.
// -----------------------------------------------------------------------------
module fs4_ddc_decim #(
  parameter int DEC_LOG2 = 3
) (
  input  logic            clk,
  input  logic            nrst,
  fs4_ddc_decim_if.slave  bus
);

  localparam int ACC_W = 17 + DEC_LOG2;
  // Half of the divisor 2^(DEC_LOG2-1). Adding it before the shift rounds half up.
  localparam logic signed [ACC_W-1:0] RND_C = ACC_W'(1 << (DEC_LOG2 - 2));

`ifdef FS4_DDC_SPECTRAL_INV_EN
  localparam bit SPEC_INV = 1'b1;
`else
  localparam bit SPEC_INV = 1'b0;
`endif

  logic        [DEC_LOG2-1:0] cnt_q, cnt_d;
  logic signed [ACC_W-1:0]    acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic                       out_valid_q, out_valid_d;
  logic signed [16:0]         out_re_q, out_re_d, out_im_q, out_im_d;

  logic        [1:0]          ph;
  logic signed [16:0]         x, nx, term_i, term_q;
  logic signed [ACC_W-1:0]    base_i, base_q, sum_i, sum_q;

  // The LO phase is the low two bits of the sample counter, so every block
  // starts at p0. A sync forces p0 for a sample that arrives with it.
  assign ph = bus.sync ? 2'd0 : cnt_q[1:0];
  assign x  = {bus.in_data[15], bus.in_data};
  assign nx = -x;  // -(-32768) = +32768 still fits in 17 signed bits

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave
    // it unassigned and infer a latch.
    term_i = '0;
    term_q = '0;
    case (ph)
      2'd0: term_i = x;
      2'd1: term_q = SPEC_INV ? x : nx;
      2'd2: term_i = nx;
      default: term_q = SPEC_INV ? nx : x;
    endcase
  end

  // A sync discards the partial block, so the incoming term adds to zero.
  assign base_i = bus.sync ? '0 : acc_i_q;
  assign base_q = bus.sync ? '0 : acc_q_q;
  assign sum_i  = base_i + {{DEC_LOG2{term_i[16]}}, term_i};
  assign sum_q  = base_q + {{DEC_LOG2{term_q[16]}}, term_q};

  always_comb begin
    cnt_d       = cnt_q;
    acc_i_d     = acc_i_q;
    acc_q_d     = acc_q_q;
    out_valid_d = 1'b0;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    if (bus.in_valid) begin
      if (!bus.sync && (cnt_q == '1)) begin
        // The last sample of the block. Dump the rounded mean of the
        // 2^(DEC_LOG2-1) nonzero terms per channel and start a fresh block.
        out_valid_d = 1'b1;
        out_re_d    = 17'((sum_i + RND_C) >>> (DEC_LOG2 - 1));
        out_im_d    = 17'((sum_q + RND_C) >>> (DEC_LOG2 - 1));
        acc_i_d     = '0;
        acc_q_d     = '0;
        cnt_d       = '0;
      end else begin
        acc_i_d = sum_i;
        acc_q_d = sum_q;
        cnt_d   = (bus.sync ? '0 : cnt_q) + 1'b1;
      end
    end else if (bus.sync) begin
      acc_i_d = '0;
      acc_q_d = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q       <= '0;
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments. Then every
      // register samples pre-edge values, whatever the statement order.
      cnt_q       <= cnt_d;
      acc_i_q     <= acc_i_d;
      acc_q_q     <= acc_q_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_real  = out_re_q;
  assign bus.out_imag  = out_im_q;
  assign bus.blk_phase = cnt_q[1:0];

endmodule
